// File: rtl/rv_load_store_unit.sv
// ---------------------------------------------------------------------------
// rv_load_store_unit
//
// Data-memory access stage sitting after the execute ALU. A load or store is
// accepted from the core, checked for a legal funct3 and natural alignment,
// run as a request/grant(/rvalid) transaction on the data bus, and answered
// with extended load data plus an error code. busy stalls the core for the
// whole access.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The unit never drops resp_valid or changes resp_rdata/resp_err
// before resp_ready. mem_req holds addr/we/wstrb/wdata stable until mem_gnt.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_store             1 = store, 0 = load
//   req_funct3            RISC-V funct3 (size and signedness)
//   req_addr, req_wdata   effective address, rs2 store data
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_err              00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   busy                  high from acceptance until the response handshake
//   mem_req/mem_gnt       bus request / grant
//   mem_we, mem_addr      write enable, word-aligned address
//   mem_wstrb, mem_wdata  byte strobes, lane-replicated store data
//   mem_rvalid, mem_rdata load data return
//   dbg_state             current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
// ---------------------------------------------------------------------------
module rv_load_store_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_store;
    logic [2:0]    r_funct3;
    logic [1:0]    r_off;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic [1:0]    r_resp_err;
    logic          r_busy;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_wstrb;
    logic [31:0]   r_mem_wdata;

    logic          w_illegal;
    logic          w_misaligned;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [31:0]   w_shift;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_tmo;

    // Decode of the request presented in IDLE.
    always_comb begin
        w_illegal    = 1'b1;
        w_misaligned = 1'b0;
        w_wstrb      = 4'b1111;
        w_wdata      = req_wdata;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b100, 3'b101:         w_illegal = req_store;
            default:                w_illegal = 1'b1;
        endcase
        // funct3[1:0] is the access size: 00 byte, 01 half, 10 word
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
        case (req_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Lane extraction and extension of the returned load word.
    always_comb begin
        w_shift = mem_rdata >> {r_off, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_store      <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= ERR_OK;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store     <= req_store;
                        r_funct3    <= req_funct3;
                        r_off       <= req_addr[1:0];
                        r_mem_addr  <= {req_addr[31:2], 2'b00};
                        r_mem_wstrb <= req_store ? w_wstrb : 4'b0000;
                        r_mem_wdata <= req_store ? w_wdata : 32'd0;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        // illegal funct3 outranks misalignment
                        if (w_illegal || w_misaligned) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_resp_err   <= w_illegal ? ERR_F3 : ERR_ALIGN;
                        end else begin
                            r_state   <= S_REQ;
                            r_cnt     <= '0;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= req_store;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_store) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_resp_err   <= ERR_OK;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= '0;
                        end
                    end else if (w_tmo) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_load;
                        r_resp_err   <= ERR_OK;
                    end else if (w_tmo) begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= ERR_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // a late mem_rvalid lands here or in IDLE and is ignored
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= ERR_OK;
                        r_busy       <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_wdata  = r_mem_wdata;
    assign dbg_state  = r_state;

endmodule
